// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state names, line idle level, baud divider helper.
// Pure declarations, no timing or flow control of its own.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK_WAIT
  } uart_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic int bitTicks(input int clockFrequency, input int baudRate);
    return clockFrequency / baudRate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud down-counter: load half or full bit period, tick_o high while the count sits at zero.
// A load takes effect on the next edge; tick_o follows combinationally; no backpressure.
module uart_bit_timer #(
  parameter int BitTicks = 2500
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic loadHalf_i,
  input  logic loadFull_i,
  output logic tick_o
);

  localparam int HalfTicks = BitTicks / 2;
  localparam int CntW      = $clog2(BitTicks);

  logic [CntW-1:0] cnt_q;

  // Loading N-1 makes the owner act exactly N edges after the load.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (loadFull_i) begin
      cnt_q <= CntW'(BitTicks - 1);
    end else if (loadHalf_i) begin
      cnt_q <= CntW'(HalfTicks - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, LSB first, dataValid ~2+Half+(N+1)*Bit cycles after start edge.
// No backpressure or buffering: dataBits holds until the next good frame, consumer must take it on dataValid.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 24_000_000,
  parameter int BaudRate       = 9600,
  parameter int NrOfDataBits   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx,
  output logic [NrOfDataBits-1:0] dataBits,
  output logic                    dataValid,
  output logic                    framingError,
  output logic                    busy
);

  localparam int BitTicks = bitTicks(ClockFrequency, BaudRate);
  localparam int IdxW     = (NrOfDataBits > 1) ? $clog2(NrOfDataBits) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrOfDataBits - 1);

  if (BitTicks < 4) begin : g_bad_baud
    $error("uart_rx: ClockFrequency/BaudRate must be at least 4");
  end
  if (NrOfDataBits < 1 || NrOfDataBits > 16) begin : g_bad_width
    $error("uart_rx: NrOfDataBits must be 1..16");
  end

  uart_state_e             state_q;
  logic                    rxMeta_q, rxSync_q;
  logic [NrOfDataBits-1:0] shift_q, shift_d;
  logic [IdxW-1:0]         bitIdx_q;
  logic [NrOfDataBits-1:0] dataBits_q;
  logic                    dataValid_q, framingError_q, busy_q;
  logic                    tick, loadHalf, loadFull;

  always_ff @(posedge clock) begin
    if (reset) begin
      rxMeta_q <= IDLE_LEVEL;
      rxSync_q <= IDLE_LEVEL;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  // New bit enters at the MSB so the first bit on the line ends up in bit 0.
  always_comb begin
    shift_d  = (shift_q >> 1) | (NrOfDataBits'(rxSync_q) << (NrOfDataBits - 1));
    loadHalf = (state_q == ST_IDLE) && (rxSync_q != IDLE_LEVEL);
    loadFull = tick && (((state_q == ST_START) && (rxSync_q != IDLE_LEVEL)) ||
                        (state_q == ST_DATA));
  end

  uart_bit_timer #(.BitTicks(BitTicks)) u_timer (
    .clock_i    (clock),
    .reset_i    (reset),
    .loadHalf_i (loadHalf),
    .loadFull_i (loadFull),
    .tick_o     (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      shift_q        <= '0;
      bitIdx_q       <= '0;
      dataBits_q     <= '0;
      dataValid_q    <= 1'b0;
      framingError_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      dataValid_q    <= 1'b0;
      framingError_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (rxSync_q != IDLE_LEVEL) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rxSync_q != IDLE_LEVEL) begin
              state_q  <= ST_DATA;
              bitIdx_q <= '0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            shift_q  <= shift_d;
            bitIdx_q <= bitIdx_q + IdxW'(1);
            if (bitIdx_q == LastIdx) begin
              state_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (rxSync_q == IDLE_LEVEL) begin
              dataBits_q  <= shift_q;
              dataValid_q <= 1'b1;
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
            end else begin
              framingError_q <= 1'b1;
              state_q        <= ST_BREAK_WAIT;
            end
          end
        end
        ST_BREAK_WAIT: begin
          if (rxSync_q == IDLE_LEVEL) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dataBits     = dataBits_q;
  assign dataValid    = dataValid_q;
  assign framingError = framingError_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 40 clocks per bit (24 MHz / 600 kBd) to keep frames short.
module tb_uart_rx;

  localparam int BIT  = 40;
  localparam int HALF = 20;
  localparam int VLD_LAT = 2 + HALF + 9 * BIT;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       tx_line = 1'b1;
  logic       start_tx = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [9:0] tx_frame;
  logic       rx;
  logic [7:0] dataBits;
  logic       dataValid, framingError, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int e_cyc   = 0;

  int         vld_cnt, ferr_cnt, ferr_cyc, busy_rise, busy_fall;
  logic [7:0] vld_dat [8];
  int         vld_cyc [8];
  logic       busy_prev = 1'b0;
  logic       both_hi = 1'b0;

  assign rx = loop_en ? tx_line : rx_drv;

  uart_rx #(
    .ClockFrequency (24_000_000),
    .BaudRate       (600_000),
    .NrOfDataBits   (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx           (rx),
    .dataBits     (dataBits),
    .dataValid    (dataValid),
    .framingError (framingError),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (dataValid) begin
      if (vld_cnt < 8) begin
        vld_dat[vld_cnt] = dataBits;
        vld_cyc[vld_cnt] = cyc;
      end
      vld_cnt++;
    end
    if (framingError) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    if (dataValid && framingError) both_hi = 1'b1;
    if (busy && !busy_prev) busy_rise = cyc;
    if (!busy && busy_prev) busy_fall = cyc;
    busy_prev = busy;
  end

  // Simple 8N1 transmitter model for the loopback scenario.
  always begin
    @(posedge clock);
    if (start_tx) begin
      tx_frame = {1'b1, sw, 1'b0};
      for (int i = 0; i < 10; i++) begin
        #1 tx_line = tx_frame[i];
        repeat (BIT) @(posedge clock);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic clear_mon();
    vld_cnt   = 0;
    ferr_cnt  = 0;
    ferr_cyc  = -1;
    busy_rise = -1;
    busy_fall = -1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    e_cyc = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      step(BIT);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    rx_drv = 1'b1;
    step(3);
    n_tests++; if (dataBits !== 8'h00) begin n_fail++; $display("FAIL reset_dataBits: got %h want 00", dataBits); end
    n_tests++; if (dataValid !== 1'b0) begin n_fail++; $display("FAIL reset_dataValid: got %b want 0", dataValid); end
    n_tests++; if (framingError !== 1'b0) begin n_fail++; $display("FAIL reset_framingError: got %b want 0", framingError); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    step(5);
    clear_mon();
  endtask

  task automatic test_single();
    int e;
    clear_mon();
    send_frame(8'hA5, 1'b1);
    e = e_cyc;
    step(10);
    n_tests++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", vld_cnt); end
    n_tests++; if (vld_dat[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", vld_dat[0]); end
    n_tests++; if (dataBits !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got %h want a5", dataBits); end
    n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt); end
    n_tests++; if (absdiff(vld_cyc[0], e + VLD_LAT) > 2) begin n_fail++; $display("FAIL single_latency: got cycle %0d want %0d +-2", vld_cyc[0], e + VLD_LAT); end
    n_tests++; if (absdiff(busy_rise, e + 2) > 2) begin n_fail++; $display("FAIL single_busy_rise: got cycle %0d want %0d +-2", busy_rise, e + 2); end
    n_tests++; if (busy_fall !== vld_cyc[0]) begin n_fail++; $display("FAIL single_busy_fall: got cycle %0d want %0d", busy_fall, vld_cyc[0]); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    step(10);
    n_tests++; if (vld_cnt !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", vld_cnt); end
    n_tests++; if (vld_dat[0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h want 00", vld_dat[0]); end
    n_tests++; if (vld_dat[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h want ff", vld_dat[1]); end
    n_tests++; if (absdiff(vld_cyc[1] - vld_cyc[0], 10 * BIT) > 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d +-2", vld_cyc[1] - vld_cyc[0], 10 * BIT); end
    n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_glitch();
    int e;
    clear_mon();
    e = cyc + 1;
    rx_drv = 1'b0;
    step(10);
    rx_drv = 1'b1;
    step(60);
    n_tests++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d want 0", vld_cnt); end
    n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b want 0", busy); end
    n_tests++; if (absdiff(busy_fall, e + 2 + HALF) > 2) begin n_fail++; $display("FAIL glitch_busy_fall: got cycle %0d want %0d +-2", busy_fall, e + 2 + HALF); end
    n_tests++; if (dataBits !== 8'hFF) begin n_fail++; $display("FAIL glitch_hold: got %h want ff", dataBits); end
  endtask

  task automatic test_framing();
    int e;
    int r;
    clear_mon();
    send_frame(8'h3C, 1'b0);
    e = e_cyc;
    step(5 * BIT);
    n_tests++; if (ferr_cnt !== 1) begin n_fail++; $display("FAIL frame_ferr_count: got %0d want 1", ferr_cnt); end
    n_tests++; if (absdiff(ferr_cyc, e + VLD_LAT) > 2) begin n_fail++; $display("FAIL frame_ferr_time: got cycle %0d want %0d +-2", ferr_cyc, e + VLD_LAT); end
    n_tests++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL frame_valid: got %0d want 0", vld_cnt); end
    n_tests++; if (dataBits !== 8'hFF) begin n_fail++; $display("FAIL frame_hold: got %h want ff", dataBits); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_break: got %b want 1", busy); end
    r = cyc + 1;
    rx_drv = 1'b1;
    step(10);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_release: got %b want 0", busy); end
    n_tests++; if (absdiff(busy_fall, r + 2) > 2) begin n_fail++; $display("FAIL frame_release_time: got cycle %0d want %0d +-2", busy_fall, r + 2); end
    clear_mon();
    send_frame(8'h55, 1'b1);
    step(10);
    n_tests++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL frame_next_count: got %0d want 1", vld_cnt); end
    n_tests++; if (vld_dat[0] !== 8'h55) begin n_fail++; $display("FAIL frame_next_data: got %h want 55", vld_dat[0]); end
    n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL frame_next_ferr: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] f;
    clear_mon();
    f = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx_drv = f[i];
      step(BIT);
    end
    reset  = 1'b1;
    rx_drv = 1'b1;
    step(1);
    reset = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_tests++; if (dataBits !== 8'h00) begin n_fail++; $display("FAIL midreset_dataBits: got %h want 00", dataBits); end
    n_tests++; if (dataValid !== 1'b0) begin n_fail++; $display("FAIL midreset_dataValid: got %b want 0", dataValid); end
    step(100);
    n_tests++; if (vld_cnt !== 0 || ferr_cnt !== 0) begin n_fail++; $display("FAIL midreset_strobes: got valid %0d ferr %0d want 0 0", vld_cnt, ferr_cnt); end
    send_frame(8'h81, 1'b1);
    step(10);
    n_tests++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL midreset_next_count: got %0d want 1", vld_cnt); end
    n_tests++; if (vld_dat[0] !== 8'h81) begin n_fail++; $display("FAIL midreset_next_data: got %h want 81", vld_dat[0]); end
  endtask

  task automatic test_loopback();
    logic [7:0] vals [3];
    vals[0] = 8'h01;
    vals[1] = 8'h80;
    vals[2] = 8'h7E;
    clear_mon();
    loop_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sw       = vals[k];
      start_tx = 1'b1;
      step(1);
      start_tx = 1'b0;
      step(10 * BIT + 20);
      n_tests++; if (vld_cnt !== k + 1) begin n_fail++; $display("FAIL loop_count_%0d: got %0d want %0d", k, vld_cnt, k + 1); end
      n_tests++; if (vld_dat[k] !== vals[k]) begin n_fail++; $display("FAIL loop_data_%0d: got %h want %h", k, vld_dat[k], vals[k]); end
    end
    loop_en = 1'b0;
    n_tests++; if (ferr_cnt !== 0) begin n_fail++; $display("FAIL loop_ferr: got %0d want 0", ferr_cnt); end
  endtask

  initial begin
    clear_mon();
    step(1);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_midframe();
    test_loopback();
    n_tests++; if (both_hi !== 1'b0) begin n_fail++; $display("FAIL strobe_overlap: got %b want 0", both_hi); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
